// File: rtl/ccc_sup_pkg.sv
// Shared types and constants for the CCC/PLL lock supervisor.
// The optional loss counter is enabled with CCC_SUP_LOSS_COUNT_EN.
package ccc_sup_pkg;

  typedef enum logic [2:0] {
    PllRst,
    WaitLock,
    Stable,
    Run,
    Fault
  } state_e;

  localparam int unsigned SyncDepth = 2;

  // Width that holds every terminal count (max - 1); never below one bit.
  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/ccc_sup_sync2.sv
// Flip-flop chain synchronizer (SyncDepth stages) for a single async level signal.
module ccc_sup_sync2
  import ccc_sup_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SyncDepth-1:0] stages_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages_q <= '0;
    end else begin
      stages_q <= {stages_q[SyncDepth-2:0], d};
    end
  end

  assign q = stages_q[SyncDepth-1];

endmodule

// File: rtl/ccc_lock_supervisor.sv
// Sequences the CCC PLL reset, qualifies LOCK and gates the GL-domain fabric reset.
// Define CCC_SUP_LOSS_COUNT_EN to build the saturating lock-loss event counter.
module ccc_lock_supervisor
  import ccc_sup_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 4096,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned LOSS_FILTER    = 4,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lock_async,
  input  logic       sw_relock,
  output logic       pll_arst_n,
  output logic       fabric_rst_n,
  output logic       locked,
  output logic       fault,
  output logic [1:0] retry_cnt,
  output logic [7:0] loss_count
);

  localparam int unsigned TW = timer_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int unsigned LW = $clog2(LOSS_FILTER + 1);

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [LW-1:0]   loss_q, loss_d;
  logic [1:0]      retry_q, retry_d;
  logic            lock_s;

  ccc_sup_sync2 u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (lock_async),
    .q     (lock_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PllRst;
      timer_q <= '0;
      loss_q  <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      loss_q  <= loss_d;
      retry_q <= retry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 1'b1;
    loss_d  = '0;
    retry_d = retry_q;
    unique case (state_q)
      PllRst: begin
        if (timer_q == TW'(PLL_RST_CYCLES - 1)) state_d = WaitLock;
      end
      WaitLock: begin
        if (lock_s) begin
          state_d = Stable;
        end else if (timer_q == TW'(LOCK_TIMEOUT - 1)) begin
          if (32'(retry_q) < MAX_RETRIES) begin
            state_d = PllRst;
            retry_d = (retry_q == 2'd3) ? retry_q : retry_q + 2'd1;
          end else begin
            state_d = Fault;
          end
        end
      end
      Stable: begin
        if (!lock_s) begin
          state_d = WaitLock;
        end else if (timer_q == TW'(STABLE_CYCLES - 1)) begin
          state_d = Run;
          retry_d = '0;
        end
      end
      Run: begin
        timer_d = timer_q;
        if (!lock_s) begin
          loss_d = loss_q + 1'b1;
          if (loss_q == LW'(LOSS_FILTER - 1)) state_d = PllRst;
        end
      end
      Fault: begin
        timer_d = timer_q;
      end
      default: state_d = PllRst;
    endcase
    // Software re-lock overrides any transition decided above.
    if (sw_relock) begin
      state_d = PllRst;
      retry_d = '0;
    end
    if (sw_relock || (state_d != state_q)) begin
      timer_d = '0;
      loss_d  = '0;
    end
  end

  always_comb begin
    pll_arst_n   = state_q inside {WaitLock, Stable, Run};
    fabric_rst_n = (state_q == Run);
    locked       = (state_q == Run);
    fault        = (state_q == Fault);
    retry_cnt    = retry_q;
  end

`ifdef CCC_SUP_LOSS_COUNT_EN
  logic [7:0] loss_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_count_q <= '0;
    end else if ((state_q == Run) && (state_d == PllRst) && !sw_relock &&
                 (loss_count_q != 8'hff)) begin
      loss_count_q <= loss_count_q + 8'd1;
    end
  end

  assign loss_count = loss_count_q;
`else
  assign loss_count = '0;
`endif

endmodule

// File: tb/tb_ccc_lock_supervisor.sv
// Directed, table-driven bench for ccc_lock_supervisor with short timing parameters.
module tb_ccc_lock_supervisor;

`ifdef CCC_SUP_LOSS_COUNT_EN
  localparam bit LossEn = 1'b1;
`else
  localparam bit LossEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lock_async;
  logic       sw_relock;
  logic       pll_arst_n;
  logic       fabric_rst_n;
  logic       locked;
  logic       fault;
  logic [1:0] retry_cnt;
  logic [7:0] loss_count;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  ccc_lock_supervisor #(
    .PLL_RST_CYCLES (4),
    .LOCK_TIMEOUT   (32),
    .STABLE_CYCLES  (8),
    .LOSS_FILTER    (3),
    .MAX_RETRIES    (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lock_async   (lock_async),
    .sw_relock    (sw_relock),
    .pll_arst_n   (pll_arst_n),
    .fabric_rst_n (fabric_rst_n),
    .locked       (locked),
    .fault        (fault),
    .retry_cnt    (retry_cnt),
    .loss_count   (loss_count)
  );

  typedef struct {
    int         n;
    logic       lock;
    logic       relock;
    logic       pll;
    logic       fab;
    logic       lkd;
    logic       flt;
    logic [1:0] retry;
    logic [7:0] losses;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input logic lock, input logic relock, input logic pll,
                     input logic fab, input logic lkd, input logic flt, input logic [1:0] retry,
                     input logic [7:0] losses);
    vec_t v;
    v.n = n; v.lock = lock; v.relock = relock; v.pll = pll; v.fab = fab;
    v.lkd = lkd; v.flt = flt; v.retry = retry; v.losses = losses;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_all(input string tag, input logic pll, input logic fab, input logic lkd,
                         input logic flt, input logic [1:0] retry, input logic [7:0] losses);
    chk({tag, "_pll_arst_n"}, {7'd0, pll_arst_n}, {7'd0, pll});
    chk({tag, "_fabric_rst_n"}, {7'd0, fabric_rst_n}, {7'd0, fab});
    chk({tag, "_locked"}, {7'd0, locked}, {7'd0, lkd});
    chk({tag, "_fault"}, {7'd0, fault}, {7'd0, flt});
    chk({tag, "_retry_cnt"}, {6'd0, retry_cnt}, {6'd0, retry});
    chk({tag, "_loss_count"}, loss_count, LossEn ? losses : 8'd0);
  endtask

  initial begin
    // Cycle k = state after the k-th clock edge following reset release.
    //  n   lock rel  pll fab lkd flt rty loss     cycle reached
    add(3,  0,   0,   0,  0,  0,  0,  0,  0);   // 3   PLL_RST cycles 0-3
    add(1,  0,   0,   1,  0,  0,  0,  0,  0);   // 4   WAIT_LOCK
    add(6,  0,   0,   1,  0,  0,  0,  0,  0);   // 10  lock raised here
    add(10, 1,   0,   1,  0,  0,  0,  0,  0);   // 20  still STABLE
    add(1,  1,   0,   1,  1,  1,  0,  0,  0);   // 21  RUN
    add(2,  0,   0,   1,  1,  1,  0,  0,  0);   // 23  two-cycle dip starts
    add(5,  1,   0,   1,  1,  1,  0,  0,  0);   // 28  dip filtered
    add(4,  0,   0,   1,  1,  1,  0,  0,  0);   // 32  third low lock_s
    add(1,  0,   0,   0,  0,  0,  0,  0,  1);   // 33  loss -> PLL_RST
    add(3,  0,   0,   0,  0,  0,  0,  0,  1);   // 36
    add(1,  0,   0,   1,  0,  0,  0,  0,  1);   // 37  WAIT_LOCK
    add(5,  1,   0,   1,  0,  0,  0,  0,  1);   // 42  lock high 5 cycles
    add(1,  0,   0,   1,  0,  0,  0,  0,  1);   // 43  one-cycle glitch
    add(5,  1,   0,   1,  0,  0,  0,  0,  1);   // 48  RUN here without glitch
    add(5,  1,   0,   1,  0,  0,  0,  0,  1);   // 53
    add(1,  1,   0,   1,  1,  1,  0,  0,  1);   // 54  RUN after restart
    add(1,  0,   1,   0,  0,  0,  0,  0,  1);   // 55  sw_relock from RUN
    add(4,  0,   0,   1,  0,  0,  0,  0,  1);   // 59  WAIT_LOCK, no lock
    add(31, 0,   0,   1,  0,  0,  0,  0,  1);   // 90  last timeout cycle
    add(1,  0,   0,   0,  0,  0,  0,  1,  1);   // 91  first timeout
    add(36, 0,   0,   0,  0,  0,  0,  2,  1);   // 127 second timeout
    add(35, 0,   0,   1,  0,  0,  0,  2,  1);   // 162
    add(1,  0,   0,   0,  0,  0,  1,  2,  1);   // 163 third timeout -> FAULT
    add(10, 0,   0,   0,  0,  0,  1,  2,  1);   // 173 FAULT holds
    add(1,  0,   1,   0,  0,  0,  0,  0,  1);   // 174 sw_relock clears FAULT
    add(3,  0,   0,   0,  0,  0,  0,  0,  1);   // 177
    add(1,  0,   0,   1,  0,  0,  0,  0,  1);   // 178 WAIT_LOCK, lock raised
    add(10, 1,   0,   1,  0,  0,  0,  0,  1);   // 188
    add(1,  1,   0,   1,  1,  1,  0,  0,  1);   // 189 RUN again

    rst_n = 1'b0;
    lock_async = 1'b0;
    sw_relock = 1'b0;
    tick(3);
    rst_n = 1'b1;
    chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      lock_async = vecs[i].lock;
      sw_relock  = vecs[i].relock;
      tick(vecs[i].n);
      sw_relock  = 1'b0;
      chk_all($sformatf("vec%0d", i), vecs[i].pll, vecs[i].fab, vecs[i].lkd, vecs[i].flt,
              vecs[i].retry, vecs[i].losses);
    end

    // Asynchronous reset while in RUN: outputs drop before the next edge.
    tick(2);
    chk("run_before_arst", {7'd0, locked}, 8'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);

    // sw_relock inside PLL_RST restarts the reset-hold count.
    lock_async = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(2);
    sw_relock = 1'b1;
    tick(1);
    sw_relock = 1'b0;
    chk("relock_rst_c3", {7'd0, pll_arst_n}, 8'd0);
    tick(1);
    chk("relock_rst_c4", {7'd0, pll_arst_n}, 8'd0);
    tick(2);
    chk("relock_rst_c6", {7'd0, pll_arst_n}, 8'd0);
    tick(1);
    chk("relock_rst_c7", {7'd0, pll_arst_n}, 8'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
